// File: rtl/ao_in_debounce_if.sv
// Signal bundle between raw input lines, the debounce stage and its consumers.
// The master side drives the raw lines and the sample qualifier.
interface ao_in_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] raw_in;
    logic             tick;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             chg;
    logic             stable;

    modport master (output raw_in, tick, input out, rise, fall, chg, stable);
    modport slave  (input raw_in, tick, output out, rise, fall, chg, stable);
endinterface

// File: rtl/ao_in_debounce.sv
// Synchronizes, debounces and edge-detects the a/b/c/d operand inputs of the and-or gates.
// Each channel accepts a new level only after DB_CYCLES consecutive qualified mismatching samples.
module ao_in_debounce #(
    parameter int               WIDTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               DB_CYCLES   = 8,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input logic           clk,
    input logic           rst_n,
    ao_in_debounce_if.slave bus
);
    localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced;

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             chg_q;
    logic             stable_c;

    // Synchronizer chain runs every clock; the tick qualifier only gates counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchronizer is a small register array, not a RAM, so every stage
            // is reset explicitly to keep out and synced consistent right after release.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's old value,
            // which is what gives a real shift register rather than a single flop.
            sync_q[0] <= bus.raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int ch = 0; ch < WIDTH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            case (state_q[ch])
                IDLE: begin
                    if (synced[ch] != out_q[ch] && bus.tick) begin
                        cnt_d[ch]   = CNT_W'(1);
                        state_d[ch] = PEND;
                    end
                end
                PEND: begin
                    if (synced[ch] == out_q[ch]) begin
                        // Input fell back before qualifying: drop it silently.
                        cnt_d[ch]   = '0;
                        state_d[ch] = IDLE;
                    end else if (bus.tick) begin
                        if (cnt_q[ch] == CNT_LAST) begin
                            out_d[ch]   = synced[ch];
                            rise_d[ch]  = synced[ch];
                            fall_d[ch]  = ~synced[ch];
                            cnt_d[ch]   = '0;
                            state_d[ch] = IDLE;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    cnt_d[ch]   = '0;
                    state_d[ch] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                state_q[ch] <= IDLE;
                cnt_q[ch]   <= '0;
            end
            out_q  <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= |(rise_d | fall_d);
        end
    end

    always_comb begin
        stable_c = 1'b1;
        for (int ch = 0; ch < WIDTH; ch++) begin
            if (synced[ch] != out_q[ch] || cnt_q[ch] != '0) stable_c = 1'b0;
        end
    end

    assign bus.out    = out_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.chg    = chg_q;
    assign bus.stable = stable_c;

endmodule

// File: tb/tb_ao_in_debounce.sv
// Directed bench for ao_in_debounce with default parameters (2 sync stages, 8-sample debounce).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ao_in_debounce;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    ao_in_debounce_if #(.WIDTH(WIDTH)) bus ();

    ao_in_debounce #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2),
        .DB_CYCLES  (8),
        .RST_VAL    (4'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b1;
        bus.raw_in = 4'hF;
        bus.tick   = 1'b1;

        // Asynchronous reset asserted between edges takes effect immediately.
        step(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_out",    8'(bus.out),    8'h0);
        check("rst_rise",   8'(bus.rise),   8'h0);
        check("rst_fall",   8'(bus.fall),   8'h0);
        check("rst_chg",    8'(bus.chg),    8'h0);
        check("rst_stable", 8'(bus.stable), 8'h1);

        bus.raw_in = 4'h0;
        step(3);
        rst_n = 1'b1;
        step(3);
        check("post_rst_out",    8'(bus.out),    8'h0);
        check("post_rst_stable", 8'(bus.stable), 8'h1);

        // Clean rising edge on channel a: out follows after edge k+9.
        bus.raw_in = 4'h1;
        step(1);
        check("clean_stable_k",   8'(bus.stable), 8'h1);
        step(1);
        check("clean_stable_k1",  8'(bus.stable), 8'h0);
        step(7);
        check("clean_out_k8",     8'(bus.out),    8'h0);
        check("clean_stable_k8",  8'(bus.stable), 8'h0);
        check("clean_rise_k8",    8'(bus.rise),   8'h0);
        step(1);
        check("clean_out_k9",     8'(bus.out),    8'h1);
        check("clean_rise_k9",    8'(bus.rise),   8'h1);
        check("clean_chg_k9",     8'(bus.chg),    8'h1);
        check("clean_stable_k9",  8'(bus.stable), 8'h1);
        step(1);
        check("clean_rise_k10",   8'(bus.rise),   8'h0);
        check("clean_chg_k10",    8'(bus.chg),    8'h0);
        check("clean_out_k10",    8'(bus.out),    8'h1);

        // Glitch on channel c lasting 7 samples: one short of acceptance.
        bus.raw_in = 4'h5;
        for (int i = 0; i < 14; i++) begin
            if (i == 7) bus.raw_in = 4'h1;
            step(1);
            check("glitch_chg", 8'(bus.chg), 8'h0);
        end
        check("glitch_out",    8'(bus.out),    8'h1);
        check("glitch_stable", 8'(bus.stable), 8'h1);

        // Simultaneous accept on two channels, first to out=8 then back to out=1.
        bus.raw_in = 4'h8;
        step(10);
        check("sim1_out",  8'(bus.out),  8'h8);
        check("sim1_rise", 8'(bus.rise), 8'h8);
        check("sim1_fall", 8'(bus.fall), 8'h1);
        check("sim1_chg",  8'(bus.chg),  8'h1);
        step(1);
        check("sim1_chg_off", 8'(bus.chg), 8'h0);
        bus.raw_in = 4'h1;
        step(9);
        check("sim2_out_early", 8'(bus.out), 8'h8);
        step(1);
        check("sim2_out",  8'(bus.out),  8'h1);
        check("sim2_rise", 8'(bus.rise), 8'h1);
        check("sim2_fall", 8'(bus.fall), 8'h8);
        check("sim2_chg",  8'(bus.chg),  8'h1);
        step(1);
        check("sim2_rise_off", 8'(bus.rise), 8'h0);
        check("sim2_fall_off", 8'(bus.fall), 8'h0);
        check("sim2_chg_off",  8'(bus.chg),  8'h0);

        // Tick on every 4th edge: channel b accepts on the 8th ticked mismatching edge.
        bus.raw_in = 4'h3;
        for (int i = 0; i < 32; i++) begin
            bus.tick = (i % 4 == 3);
            step(1);
            if (i == 27) check("tick_out_7th", 8'(bus.out), 8'h1);
            if (i == 30) check("tick_out_hold", 8'(bus.out), 8'h1);
            if (i == 31) begin
                check("tick_out_8th", 8'(bus.out),  8'h3);
                check("tick_rise",    8'(bus.rise), 8'h2);
            end
        end
        bus.tick = 1'b1;
        step(1);
        check("tick_rise_off", 8'(bus.rise), 8'h0);

        // Reset while channel d is pending with cnt=5, then full latency after release.
        bus.raw_in = 4'hB;
        step(7);
        check("mid_out_pre", 8'(bus.out), 8'h3);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out",  8'(bus.out),  8'h0);
        check("mid_rst_rise", 8'(bus.rise), 8'h0);
        check("mid_rst_fall", 8'(bus.fall), 8'h0);
        check("mid_rst_chg",  8'(bus.chg),  8'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(9);
        check("mid_out_early", 8'(bus.out),  8'h0);
        check("mid_fall_none", 8'(bus.fall), 8'h0);
        step(1);
        check("mid_out_late",  8'(bus.out),  8'hB);
        check("mid_rise_late", 8'(bus.rise), 8'hB);
        check("mid_chg_late",  8'(bus.chg),  8'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
